// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read port, occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow bits.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     err_clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_ok;
  logic             rd_ok;

  // Gating on the registered flags resolves the full/empty simultaneous cases:
  // full admits only the read, empty admits only the write.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        rptr    <= rptr + 1'b1;
        rd_data <= mem[rptr];
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error in the clearing cycle keeps the bit set.
      overflow  <= (overflow  && !err_clr) || (wr_en && full);
      underflow <= (underflow && !err_clr) || (rd_en && empty);
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench for sync_fifo_param against a queue-based model.
module tb_sync_fifo_param;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = D - 2;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst, err_clr, wr_en, rd_en;
  logic [W-1:0] wr_data, rd_data;
  logic         rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]   count;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .err_clr(err_clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  int unsigned  total = 0;
  int unsigned  bad   = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  logic         m_ovf, m_unf;
  logic [W-1:0] last_rd;

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and advance the reference model to its post-edge state.
  task automatic step(input bit r, input bit w, input bit rd, input logic [W-1:0] d, input bit clr);
    bit fm, em;
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd; wr_data = d; err_clr = clr;
    if (r) begin
      mq.delete(); exp_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; last_rd = '0;
    end else begin
      fm = (mq.size() == D);
      em = (mq.size() == 0);
      if (rd && !em) begin
        last_rd = mq.pop_front();
        exp_q.push_back(last_rd);
      end
      if (w && !fm) mq.push_back(d);
      m_ovf = (w && fm) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = (rd && em) ? 1'b1 : (clr ? 1'b0 : m_unf);
    end
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      chk("rd_valid", int'(rd_valid), int'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (rd_valid) chk("rd_data", int'(rd_data), int'(e));
      end
      chk("rd_data_hold", int'(rd_data), int'(last_rd));
      chk("count", int'(count), mq.size());
      chk("full", int'(full), int'(mq.size() == D));
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("almost_full", int'(almost_full), int'(mq.size() >= AF));
      chk("almost_empty", int'(almost_empty), int'(mq.size() <= AE));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_unf));
    end
  end

  initial begin : driver
    int unsigned wp;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; err_clr = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; last_rd = '0;
    step(1, 0, 0, '0, 0);

    // fill, overflow, clear, drain
    for (int i = 0; i < D; i++) step(0, 1, 0, W'(i), 0);
    step(0, 1, 0, 8'hAA, 0);
    step(0, 0, 0, '0, 1);
    for (int i = 0; i < D; i++) step(0, 0, 1, '0, 0);

    // underflow, simultaneous access on empty, error-wins-over-clear
    step(0, 0, 1, '0, 0);
    step(0, 1, 1, 8'h5C, 0);
    step(0, 0, 1, '0, 1);
    step(0, 0, 1, '0, 1);
    step(0, 0, 0, '0, 1);

    // pointer wrap at constant occupancy 5
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, W'($urandom), 0);
    for (int i = 0; i < 40; i++) step(0, 1, 1, W'($urandom), 0);

    // simultaneous access on full, then reset mid-traffic at occupancy 9
    for (int i = 0; i < D - 5; i++) step(0, 1, 0, W'($urandom), 0);
    step(0, 1, 1, 8'hEE, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, '0, 0);
    step(1, 1, 1, 8'h33, 0);
    step(0, 0, 0, '0, 0);

    // random traffic with a drifting write bias so both ends are exercised
    for (int i = 0; i < 600; i++) begin
      wp = ((i / 60) % 2 == 0) ? 80 : 20;
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < wp,
           $urandom_range(0, 99) < (100 - wp),
           W'($urandom),
           $urandom_range(0, 7) == 0);
    end

    step(0, 0, 0, '0, 0);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock synchronous FIFO for the common RTL library. It buffers `WIDTH`-bit words in a `DEPTH`-entry memory and provides a registered read port, an occupancy count and programmable almost-full and almost-empty flags. Sticky overflow and underflow error bits record rejected accesses. It is the general buffering primitive that example and datapath designs instantiate between producer and consumer logic on the same clock.

## Interface
- `WIDTH`, 8: data word width in bits, ≥1.
- `DEPTH`, 16: number of entries; must be a power of two, ≥2.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- `AE_LEVEL`, 2: `almost_empty` asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `err_clr` in 1: synchronous clear of the `overflow` and `underflow` bits.
- `wr_en` in 1: write request.
- `wr_data` in WIDTH: write word, sampled when a write is accepted.
- `rd_en` in 1: read request.
- `rd_data` out WIDTH: registered read word.
- `rd_valid` out 1: one-cycle pulse marking a new word on `rd_data`.
- `count` out clog2(DEPTH)+1: number of stored entries, 0..DEPTH.
- `full`, `empty`, `almost_full`, `almost_empty` out 1 each: status flags.
- `overflow`, `underflow` out 1 each: sticky error bits.

## Operation
- Storage is a DEPTH×WIDTH array. Write and read pointers are clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- A write is accepted when `wr_en && !full`. The word goes to `mem[wptr]` and `wptr` increments.
- A read is accepted when `rd_en && !empty`. `mem[rptr]` goes to `rd_data`, `rptr` increments, and `rd_valid` is 1 on the next cycle.
- Count update:
  - Accepted write only: +1.
  - Accepted read only: −1.
  - Both accepted: count unchanged; both pointers advance.
- Full with `wr_en && rd_en`: the read is accepted, the write is rejected, `overflow` sets, and count goes to DEPTH−1.
- Empty with `wr_en && rd_en`: the write is accepted, the read is rejected, `underflow` sets, and count goes to 1. There is no fall-through; the new word is readable from the next cycle.
- `wr_en` while full (no read) is rejected and sets `overflow`. Memory, pointers and count do not change.
- `rd_en` while empty is rejected and sets `underflow`. `rd_data` holds and `rd_valid` is 0.
- `rd_data` holds its last value whenever no read is accepted.
- Flags are combinational decodes of the registered `count`:
  - `full` = (count == DEPTH).
  - `empty` = (count == 0).
  - `almost_full` = (count ≥ AF_LEVEL).
  - `almost_empty` = (count ≤ AE_LEVEL).
- Error bits:
  - `overflow` and `underflow` stay set until `rst` or `err_clr`.
  - If `err_clr` and a new error occur in the same cycle, the error wins and the bit stays 1.
- Reset values: pointers = 0, `count` = 0, `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0 (AF_LEVEL ≥ 1), `rd_data` = 0, `rd_valid` = 0, `overflow` = 0, `underflow` = 0. Memory contents are not reset.
- Reset takes priority over `wr_en`, `rd_en` and `err_clr` in the same cycle. A reset in the middle of traffic discards all stored data.

## Timing
- Write-to-read latency:
  - An accepted write at edge N makes `empty` = 0 after edge N.
  - The earliest read is accepted at edge N+1, with `rd_data` and `rd_valid` valid after edge N+1.
- Read latency is 1 cycle from the accepted `rd_en` edge to `rd_data` and `rd_valid`.
- Flags and `count` reflect all accesses accepted at the preceding edge. No flag lags `count`.
- Sustained throughput is one write and one read per cycle at any occupancy between 1 and DEPTH−1.
- There are no combinational paths from `wr_en` or `rd_en` to any output.

## Test plan
- Reset, then fill (DEPTH=16): write 0x00..0x0F on 16 consecutive cycles, then drain with 16 reads.
  - Required response: `rd_data` = 0x00..0x0F in order, each with a one-cycle `rd_valid`.
  - Flags: `almost_full` at count 14, `full` at count 16, `almost_empty` at count ≤ 2, `empty` at count 0.
- Write 0xAA while full.
  - Required response: `count` stays 16, `overflow` = 1, and the drain returns no 0xAA.
  - Then assert `err_clr`: `overflow` = 0 the next cycle.
- Read while empty.
  - Required response: `underflow` = 1, `rd_valid` = 0, `rd_data` unchanged.
  - Then assert `wr_en` and `rd_en` together while empty: count = 1, and the stored word is read out on the next read.
- Wrap-around: run 40 cycles with `wr_en` and `rd_en` both high and count held at 5.
  - Required response: output order matches input order across pointer wrap, and `count` stays 5 throughout.
- Assert `wr_en` and `rd_en` together while full.
  - Required response: the oldest word is read, count = 15, `overflow` = 1, and the dropped word never appears at the output.
- Assert `rst` with count = 9 while writing and reading.
  - Required response: the next cycle shows count 0, `empty` = 1, `rd_valid` = 0, `rd_data` = 0, and both error bits at 0.
